// File: rtl/pipe_pkg.sv
// Shared definitions for the 4-stage ADD/SUB/LOAD pipeline and its run controller.
package pipe_pkg;

    localparam int INSTR_W = 16;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] NOP  = 2'b11;

    // Bubble injected by fetch while draining; opcode NOP never writes the register file.
    localparam logic [INSTR_W-1:0] NOP_INSTR = {NOP, {(INSTR_W-2){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        HALT,
        STEP,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pipe_seq_ctrl.sv
// Run controller: loads a program into instruction memory, then sequences
// clear / run / halt / single-step / drain / done for the pipeline datapath.
module pipe_seq_ctrl #(
    parameter int IMEM_DEPTH   = 8,
    parameter int INSTR_W      = 16,
    parameter int DRAIN_CYCLES = 3,
    localparam int AW          = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    input  logic               clr_prog,
    input  logic               start,
    input  logic               halt_req,
    input  logic               step,
    output logic               imem_we,
    output logic [AW-1:0]      imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               pipe_clr,
    output logic               pipe_en,
    output logic               fetch_bubble,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        prog_len,
    output logic [AW:0]        fetch_cnt
);
    import pipe_pkg::*;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(IMEM_DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] drain_cnt;
    logic          last_fetch;
    logic          fetch_done;
    logic          fetching;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v >= DEPTH_C) ? v : v + 1'b1;
    endfunction

    assign ld_ready   = (state == IDLE) && (prog_len < DEPTH_C);
    assign imem_we    = ld_valid && ld_ready;
    assign imem_addr  = prog_len[AW-1:0];
    assign imem_wdata = ld_data;

    assign fetching   = (state == RUN) || (state == STEP);
    assign last_fetch = (sat_inc(fetch_cnt) == prog_len);
    assign fetch_done = (fetch_cnt == prog_len);

    assign pipe_clr     = (state == CLEAR);
    assign pipe_en      = fetching || (state == DRAIN);
    assign fetch_bubble = (state == DRAIN);
    assign busy         = (state == CLEAR) || fetching || (state == HALT) || (state == DRAIN);
    assign done         = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            // A beat accepted alongside start counts toward the run length.
            IDLE:  if (start && !clr_prog && (prog_len != '0 || imem_we)) state_nxt = CLEAR;
            CLEAR: state_nxt = RUN;
            RUN: begin
                if (halt_req)        state_nxt = HALT;
                else if (last_fetch) state_nxt = DRAIN;
            end
            HALT: begin
                if (start)     state_nxt = fetch_done ? DRAIN : RUN;
                else if (step) state_nxt = fetch_done ? DRAIN : STEP;
            end
            STEP:  state_nxt = HALT;
            DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE: begin
                if (clr_prog)   state_nxt = IDLE;
                else if (start) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prog_len  <= '0;
            fetch_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;

            // clr_prog wins over a coincident load beat.
            if (clr_prog && (state == IDLE || state == DONE)) prog_len <= '0;
            else if (imem_we)                                 prog_len <= sat_inc(prog_len);

            if (state == CLEAR)  fetch_cnt <= '0;
            else if (fetching)   fetch_cnt <= sat_inc(fetch_cnt);

            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl with scoreboards for imem writes and per-cycle control.
module tb_pipe_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int DRAIN = 3;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_CLEAR = 5'b10010;
    localparam logic [4:0] C_RUN   = 5'b01010;
    localparam logic [4:0] C_HALT  = 5'b00010;
    localparam logic [4:0] C_DRAIN = 5'b01110;
    localparam logic [4:0] C_DONE  = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, clr_prog, start, halt_req, step;
    logic [15:0] ld_data;
    logic        ld_ready, imem_we, pipe_clr, pipe_en, fetch_bubble, busy, done;
    logic [2:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [3:0]  prog_len, fetch_cnt;
    logic [4:0]  ctl;

    int checks   = 0;
    int failures = 0;
    int model_len = 0;

    logic [18:0] wr_q[$];
    logic [4:0]  ctl_q[$];

    pipe_seq_ctrl #(.IMEM_DEPTH(DEPTH), .INSTR_W(16), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .clr_prog(clr_prog), .start(start), .halt_req(halt_req), .step(step),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .pipe_clr(pipe_clr), .pipe_en(pipe_en), .fetch_bubble(fetch_bubble),
        .busy(busy), .done(done), .prog_len(prog_len), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pipe_clr, pipe_en, fetch_bubble, busy, done};

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every imem write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            logic [18:0] e;
            e = (wr_q.size() > 0) ? wr_q.pop_front() : 19'h7ffff;
            checks++;
            assert ({imem_addr, imem_wdata} === e) else begin
                failures++;
                $error("FAIL imem_write observed=%0h expected=%0h", {imem_addr, imem_wdata}, e);
            end
        end
    end

    task automatic load_word(input logic [15:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        if (model_len < DEPTH) begin
            wr_q.push_back({3'(model_len), d});
            model_len++;
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic push_run(input int len);
        ctl_q.push_back(C_CLEAR);
        repeat (len) ctl_q.push_back(C_RUN);
        repeat (DRAIN) ctl_q.push_back(C_DRAIN);
        ctl_q.push_back(C_DONE);
    endtask

    task automatic run_trace(input string tag);
        int n = 0;
        logic [4:0] e;
        while (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            check($sformatf("%s_cyc%0d", tag, n), 32'(ctl), 32'(e));
            n++;
            if (ctl_q.size() > 0) tick();
        end
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; clr_prog = 1'b0;
        start = 1'b0; halt_req = 1'b0; step = 1'b0;
        #3;
        check("reset_ctl", 32'(ctl), 32'(C_IDLE));
        check("reset_ready", 32'(ld_ready), 1);
        check("reset_we", 32'(imem_we), 0);
        check("reset_len", 32'(prog_len), 0);
        check("reset_fcnt", 32'(fetch_cnt), 0);
        tick();
        reset = 1'b0;
        tick();

        // Load 3 words and run.
        for (int i = 0; i < 3; i++) load_word(16'h1000 + 16'(i * 7));
        check("load3_len", 32'(prog_len), 3);
        start = 1'b1;
        push_run(model_len);
        tick();
        start = 1'b0;
        run_trace("run3");
        check("run3_fcnt", 32'(fetch_cnt), 3);
        check("run3_wrq", wr_q.size(), 0);
        clr_prog = 1'b1;
        tick();
        clr_prog = 1'b0;
        model_len = 0;
        check("done_clr_len", 32'(prog_len), 0);

        // Start with an empty program is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_start_ctl0", 32'(ctl), 32'(C_IDLE));
        tick();
        check("empty_start_ctl1", 32'(ctl), 32'(C_IDLE));

        // Nine back-to-back beats: only eight are accepted.
        for (int i = 0; i < 9; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'($urandom);
            check($sformatf("full_ready%0d", i), 32'(ld_ready), (i < DEPTH) ? 1 : 0);
            if (model_len < DEPTH) begin
                wr_q.push_back({3'(model_len), ld_data});
                model_len++;
            end
            tick();
        end
        ld_valid = 1'b0;
        check("full_len", 32'(prog_len), 8);
        check("full_wrq", wr_q.size(), 0);
        clr_prog = 1'b1;
        tick();
        clr_prog = 1'b0;
        model_len = 0;

        // L = 5 with halt on the second RUN cycle, two steps, then resume.
        for (int i = 0; i < 5; i++) load_word(16'h2000 | 16'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("halt_clear", 32'(ctl), 32'(C_CLEAR));
        tick();
        check("halt_run1", 32'(ctl), 32'(C_RUN));
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_ctl", 32'(ctl), 32'(C_HALT));
        check("halt_fcnt", 32'(fetch_cnt), 2);
        repeat (3) tick();
        check("halt_hold_ctl", 32'(ctl), 32'(C_HALT));
        check("halt_hold_fcnt", 32'(fetch_cnt), 2);
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check($sformatf("step%0d_en", s), 32'(pipe_en), 1);
            tick();
            check($sformatf("step%0d_off", s), 32'(ctl), 32'(C_HALT));
            check($sformatf("step%0d_fcnt", s), 32'(fetch_cnt), 32'(3 + s));
        end
        start = 1'b1;
        ctl_q.push_back(C_RUN);
        repeat (DRAIN) ctl_q.push_back(C_DRAIN);
        ctl_q.push_back(C_DONE);
        tick();
        start = 1'b0;
        run_trace("resume");
        check("resume_fcnt", 32'(fetch_cnt), 5);

        // Reset in the middle of DRAIN acts without a clock edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_reset_drain", 32'(ctl), 32'(C_DRAIN));
        #2;
        reset = 1'b1;
        #1;
        check("async_ctl", 32'(ctl), 32'(C_IDLE));
        check("async_len", 32'(prog_len), 0);
        check("async_ready", 32'(ld_ready), 1);
        check("async_fcnt", 32'(fetch_cnt), 0);
        #1;
        reset = 1'b0;
        model_len = 0;
        tick();

        // Load beat coincident with start joins the run; rerun from DONE; clear from DONE.
        load_word(16'hA5A5);
        load_word(16'h5A5A);
        ld_valid = 1'b1;
        ld_data  = 16'h3C3C;
        start    = 1'b1;
        wr_q.push_back({3'(model_len), 16'h3C3C});
        model_len++;
        push_run(model_len);
        tick();
        ld_valid = 1'b0;
        start    = 1'b0;
        run_trace("coinc");
        check("coinc_fcnt", 32'(fetch_cnt), 3);
        check("coinc_len", 32'(prog_len), 3);
        start = 1'b1;
        push_run(model_len);
        tick();
        start = 1'b0;
        run_trace("rerun");
        clr_prog = 1'b1;
        tick();
        clr_prog = 1'b0;
        check("final_ctl", 32'(ctl), 32'(C_IDLE));
        check("final_len", 32'(prog_len), 0);
        check("final_ready", 32'(ld_ready), 1);
        check("final_wrq", wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Run controller for the 4-stage ADD/SUB/LOAD pipeline. It loads a program into instruction memory through a valid/ready port, then sequences execution. Execution covers clearing pipeline state, enabling the stages for exactly the loaded instruction count, injecting bubbles to drain the pipeline, and reporting completion. It also supports halt, single-step and resume. It sits beside the datapath and drives its instruction-memory write port and its stage-enable and clear controls.

## Interface
Parameters:
- IMEM_DEPTH, 8: instruction memory words; also the maximum program length.
- INSTR_W, 16: instruction width.
- DRAIN_CYCLES, 3: bubble cycles needed to empty decode, execute and writeback after the last fetch.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- ld_valid  in  1  program word offered.
- ld_data  in  INSTR_W  program word.
- ld_ready  out  1  controller accepts a word this cycle.
- clr_prog  in  1  discard the loaded program (length := 0).
- start  in  1  run from address 0 in IDLE or DONE; resume in HALT.
- halt_req  in  1  freeze the pipeline in RUN.
- step  in  1  advance exactly one cycle while in HALT.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  log2(IMEM_DEPTH)  write address.
- imem_wdata  out  INSTR_W  write data, equal to ld_data.
- pipe_clr  out  1  one-cycle synchronous clear of pc and all pipeline registers.
- pipe_en  out  1  all stage registers and pc advance this cycle.
- fetch_bubble  out  1  fetch stage loads NOP_INSTR instead of instr_mem[pc].
- busy  out  1  state is CLEAR, RUN, HALT or DRAIN.
- done  out  1  state is DONE.
- prog_len  out  log2(IMEM_DEPTH)+1  words loaded.
- fetch_cnt  out  log2(IMEM_DEPTH)+1  instructions fetched in the current run.

## Operation
- States: IDLE, CLEAR, RUN, HALT, DRAIN, DONE. All control outputs are Moore decodes of the state. The exception is ld_ready/imem_we.
- IDLE:
  - ld_ready = (prog_len < IMEM_DEPTH).
  - imem_we = ld_valid & ld_ready, with imem_addr = prog_len[low bits]; prog_len increments on the same edge.
  - clr_prog sets prog_len to 0. If clr_prog and a load beat coincide, clr_prog wins and the beat is dropped; imem_we is still written, which is harmless.
  - start with a resulting length > 0 moves to CLEAR. A load beat in the same cycle is accepted and counts toward the run.
  - start with prog_len = 0 is ignored.
- CLEAR (1 cycle): pipe_clr = 1, pipe_en = 0, fetch_cnt := 0; next state is RUN.
- RUN:
  - pipe_en = 1 and fetch_cnt increments each cycle.
  - The cycle in which fetch_cnt becomes prog_len is the last RUN cycle; next state is DRAIN.
  - halt_req sampled high moves to HALT, and that cycle's pipe_en still fires. halt_req takes priority over the last-fetch transition: if both apply, the next state is HALT, and a later start or step goes straight to DRAIN.
- HALT:
  - pipe_en = 0.
  - start returns to RUN, or to DRAIN if fetch_cnt == prog_len.
  - step (with start low) gives one pipe_en = 1 cycle on the following cycle. The controller passes through RUN for exactly that one cycle and re-enters HALT; this one-cycle path may be implemented as a STEP sub-state.
  - start outranks step.
- DRAIN: pipe_en = 1 and fetch_bubble = 1 for DRAIN_CYCLES cycles; halt_req is ignored; next state is DONE.
- DONE:
  - done = 1; prog_len is retained.
  - start moves to CLEAR for a rerun; clr_prog returns to IDLE with prog_len = 0.
- Bubble encoding: NOP_INSTR = 16'hC000, opcode 2'b11, which is non-writing.
- Counters saturate logically at IMEM_DEPTH and never wrap.
- Reset values:
  - State IDLE; prog_len = 0; fetch_cnt = 0.
  - pipe_clr = 0, pipe_en = 0, fetch_bubble = 0, busy = 0, done = 0, imem_we = 0.
  - ld_ready = 1.
- Reset mid-run aborts immediately. Instruction memory contents are kept but prog_len = 0, so the program must be reloaded.

## Timing
- Load: one word per cycle at full throughput. After IMEM_DEPTH beats, ld_ready is 0 in the next cycle.
- start sampled at edge k: pipe_clr is high in cycle k+1; RUN covers cycles k+2 .. k+1+L, where L = prog_len.
- Without halts, DRAIN covers cycles k+2+L .. k+1+L+DRAIN_CYCLES, and done rises at k+2+L+DRAIN_CYCLES.
- HALT adds exactly the number of cycles spent halted. Each step adds one pipe_en cycle.

## Structure
- Shared package pipe_pkg holds:
  - opcode localparams ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, NOP = 2'b11;
  - NOP_INSTR;
  - INSTR_W;
  - the state enum.
- Single module; no sub-module is warranted. The datapath integration is the pipe_en, pipe_clr and fetch_bubble hooks.

## Test plan
- Load 3 words, start: pipe_clr 1 cycle, pipe_en 3 cycles with fetch_bubble = 0, then 3 cycles with fetch_bubble = 1, done at start+8; imem writes at addresses 0,1,2.
- Offer 9 words back-to-back: 8 imem_we pulses, ld_ready low after the 8th, prog_len = 8; the 9th word is never written.
- Start with prog_len = 0: state stays IDLE and pipe_clr is never asserted.
- L = 5, halt_req at the 2nd RUN cycle: fetch_cnt freezes at 2. Hold 4 cycles, step twice to reach fetch_cnt = 4 with two isolated pipe_en pulses, start, then 1 RUN cycle, 3 DRAIN cycles, done.
- Reset asserted mid-DRAIN: outputs drop to reset values without waiting for a clock edge; prog_len = 0, ld_ready = 1.
- Simultaneous ld_valid and start in IDLE with prog_len = 2: word written at address 2 and the run lasts 3 RUN cycles. DONE followed by start reruns identically; DONE followed by clr_prog gives IDLE with prog_len = 0.
